// File: rtl/mha_fxp_pkg.sv
// -----------------------------------------------------------------------------
// mha_fxp_pkg
// Shared fixed-point helpers for the MHA datapath blocks.
//   state_t    : controller states {IDLE, ACC, OUT}
//   sat_t      : saturation decision {SAT_NONE, SAT_HI, SAT_LO}
//   frac_bits  : number of fraction bits for a given element width
//   acc_width  : overflow-free accumulator width for NUM products
//   saturate   : decides whether a sign-extended value lies above/below the
//                signed range of a dw-bit word
// -----------------------------------------------------------------------------
package mha_fxp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SAT_NONE = 2'd0,
      SAT_HI   = 2'd1,
      SAT_LO   = 2'd2
   } sat_t;

   // 1 sign + 2 integer bits; the rest is fraction.
   function automatic int frac_bits(input int dw);
      return (dw == 16) ? 13 : 5;
   endfunction

   // Product width plus enough headroom to add NUM products.
   function automatic int acc_width(input int dw, input int num);
      return 2 * dw + $clog2(num);
   endfunction

   // Returns which rail (if any) x must be clamped to for a dw-bit result.
   // The caller supplies the rail values, so no wide result is returned.
   function automatic sat_t saturate(input logic signed [63:0] x, input int dw);
      logic signed [63:0] v_max;
      logic signed [63:0] v_min;
      v_max = (64'sd1 <<< (dw - 1)) - 64'sd1;
      v_min = -v_max - 64'sd1;
      if (x > v_max)      return SAT_HI;
      else if (x < v_min) return SAT_LO;
      else                return SAT_NONE;
   endfunction

endpackage

// File: rtl/pv_mac_lane.sv
// -----------------------------------------------------------------------------
// pv_mac_lane
// One output element of the P*V product: multiply-accumulate register plus
// the shift / optional round / saturate path that forms the output element.
// Build option: define SOFTMAX_PV_ROUND_EN to round half up before the shift;
// otherwise the shift truncates toward -inf.
// Ports:
//   I_CLK, I_RST_N : clock, synchronous active-low reset
//   I_CLR          : zero the accumulator (start of a new row)
//   I_EN           : accumulate I_P*I_V this cycle
//   I_P, I_V       : signed fixed-point operands
//   O_RES          : combinational saturated result of the current sum
// -----------------------------------------------------------------------------
module pv_mac_lane
   import mha_fxp_pkg::*;
#(
   parameter int D_W = 8,
   parameter int NUM = 16
) (
   input  logic                  I_CLK,
   input  logic                  I_RST_N,
   input  logic                  I_CLR,
   input  logic                  I_EN,
   input  logic signed [D_W-1:0] I_P,
   input  logic signed [D_W-1:0] I_V,
   output logic signed [D_W-1:0] O_RES
);

   localparam int FRAC = frac_bits(D_W);
   localparam int AW   = acc_width(D_W, NUM);
   localparam int PW   = 2 * D_W;
   localparam logic signed [D_W-1:0] SMAX = {1'b0, {(D_W-1){1'b1}}};
   localparam logic signed [D_W-1:0] SMIN = {1'b1, {(D_W-1){1'b0}}};
`ifdef SOFTMAX_PV_ROUND_EN
   localparam logic signed [AW:0] RND = (AW+1)'(1) <<< (FRAC - 1);
`else
   localparam logic signed [AW:0] RND = '0;
`endif

   logic signed [PW-1:0] w_prod;
   logic signed [AW-1:0] r_acc;
   logic signed [AW:0]   w_sum;
   logic signed [AW:0]   w_shift;
   logic signed [63:0]   w_ext;
   sat_t                 w_sat;

   assign w_prod = PW'(I_P) * PW'(I_V);

   always_ff @(posedge I_CLK) begin
      if (!I_RST_N) begin
         r_acc <= '0;
      end else if (I_CLR) begin
         r_acc <= '0;
      end else if (I_EN) begin
         r_acc <= r_acc + AW'(w_prod);
      end
   end

   // One extra bit keeps the rounding add from wrapping at the positive rail.
   assign w_sum   = (AW+1)'(r_acc) + RND;
   assign w_shift = w_sum >>> FRAC;
   assign w_ext   = 64'(w_shift);
   assign w_sat   = saturate(w_ext, D_W);

   always_comb begin
      O_RES = w_shift[D_W-1:0];
      if (w_sat == SAT_HI)      O_RES = SMAX;
      else if (w_sat == SAT_LO) O_RES = SMIN;
   end

endmodule

// File: rtl/softmax_pv_accum.sv
// -----------------------------------------------------------------------------
// softmax_pv_accum
// Latches a softmax probability row P and accumulates O[d] = sum_i P[i]*V[i][d]
// over NUM streamed V rows, then emits one saturated output row.
// Build option: SOFTMAX_PV_ROUND_EN (round half up in each lane).
// Handshake: a V row is transferred on every rising edge where I_V_VLD and
// O_V_RDY are both high; O_V_RDY is high exactly while in ACC and does not
// depend on I_V_VLD. I_V_VLD may drop at any time.
// Ports:
//   I_CLK, I_RST_N : clock, synchronous active-low reset
//   I_START        : operation enable, low aborts
//   I_P_VLD, I_P   : probability row (sampled only in IDLE)
//   I_V_VLD, O_V_RDY, I_V : V row stream
//   O_ROW_IDX      : index of the V row expected next
//   O_VLD, O_DATA  : one-cycle result pulse, result row held until next one
//   O_DBG_STATE    : current controller state
// -----------------------------------------------------------------------------
module softmax_pv_accum
   import mha_fxp_pkg::*;
#(
   parameter int D_W = 8,
   parameter int NUM = 16,
   parameter int DIM = 16
) (
   input  logic                       I_CLK,
   input  logic                       I_RST_N,
   input  logic                       I_START,
   input  logic                       I_P_VLD,
   input  logic signed [D_W-1:0]      I_P [0:NUM-1],
   input  logic                       I_V_VLD,
   output logic                       O_V_RDY,
   output logic [$clog2(NUM)-1:0]     O_ROW_IDX,
   input  logic signed [D_W-1:0]      I_V [0:DIM-1],
   output logic                       O_VLD,
   output logic signed [D_W-1:0]      O_DATA [0:DIM-1],
   output logic [1:0]                 O_DBG_STATE
);

   localparam int RW = $clog2(NUM);
   localparam logic [RW-1:0] LAST = RW'(NUM - 1);

   state_t                r_state;
   logic [RW-1:0]         r_row;
   logic                  r_vld;
   logic signed [D_W-1:0] r_p    [0:NUM-1];
   logic signed [D_W-1:0] r_data [0:DIM-1];
   logic signed [D_W-1:0] w_res  [0:DIM-1];
   logic                  w_hs;
   logic                  w_clr;

   assign O_V_RDY     = (r_state == ACC);
   assign w_hs        = I_V_VLD && O_V_RDY;
   assign w_clr       = (r_state == IDLE) && I_START && I_P_VLD;
   assign O_ROW_IDX   = r_row;
   assign O_VLD       = r_vld;
   assign O_DATA      = r_data;
   assign O_DBG_STATE = r_state;

   for (genvar d = 0; d < DIM; d++) begin : g_lane
      pv_mac_lane #(
         .D_W (D_W),
         .NUM (NUM)
      ) u_lane (
         .I_CLK   (I_CLK),
         .I_RST_N (I_RST_N),
         .I_CLR   (w_clr),
         .I_EN    (w_hs),
         .I_P     (r_p[r_row]),
         .I_V     (I_V[d]),
         .O_RES   (w_res[d])
      );
   end

   always_ff @(posedge I_CLK) begin
      if (!I_RST_N) begin
         r_state <= IDLE;
         r_row   <= '0;
         r_vld   <= 1'b0;
         for (int k = 0; k < NUM; k++) r_p[k] <= '0;
         for (int k = 0; k < DIM; k++) r_data[k] <= '0;
      end else begin
         r_vld <= 1'b0;
         case (r_state)
            IDLE: begin
               if (I_START && I_P_VLD) begin
                  r_p     <= I_P;
                  r_row   <= '0;
                  r_state <= ACC;
               end
            end
            ACC: begin
               if (!I_START) begin
                  // Abort: partial sums are cleared on the next start.
                  r_row   <= '0;
                  r_state <= IDLE;
               end else if (w_hs) begin
                  if (r_row == LAST) begin
                     r_row   <= '0;
                     r_state <= OUT;
                  end else begin
                     r_row <= r_row + RW'(1);
                  end
               end
            end
            OUT: begin
               r_state <= IDLE;
               if (I_START) begin
                  r_data <= w_res;
                  r_vld  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_pv_accum.sv
// -----------------------------------------------------------------------------
// tb_softmax_pv_accum
// Directed and randomized checks of softmax_pv_accum (D_W=8, NUM=16, DIM=4)
// against a plain-arithmetic dot-product model.
// -----------------------------------------------------------------------------
module tb_softmax_pv_accum;
  import mha_fxp_pkg::*;

  localparam int D_W  = 8;
  localparam int NUM  = 16;
  localparam int DIM  = 4;
  localparam int FRAC = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start, p_vld, v_vld, v_rdy, o_vld;
  logic signed [7:0] p_in [0:NUM-1];
  logic signed [7:0] v_in [0:DIM-1];
  logic signed [7:0] o_data [0:DIM-1];
  logic [3:0]        row_idx;
  logic [1:0]        dbg_state;

  softmax_pv_accum #(.D_W(D_W), .NUM(NUM), .DIM(DIM)) dut (
    .I_CLK       (clk),
    .I_RST_N     (rst_n),
    .I_START     (start),
    .I_P_VLD     (p_vld),
    .I_P         (p_in),
    .I_V_VLD     (v_vld),
    .O_V_RDY     (v_rdy),
    .O_ROW_IDX   (row_idx),
    .I_V         (v_in),
    .O_VLD       (o_vld),
    .O_DATA      (o_data),
    .O_DBG_STATE (dbg_state)
  );

  // scoreboard
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_row [0:DIM-1];
  int         rdy_cnt;

  // reference model state
  int p_m [0:NUM-1];
  int v_m [0:NUM-1][0:DIM-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // O[d] = sat(floor((sum_i P[i]*V[i][d] + rnd) / 2^FRAC))
  function automatic int ref_elem(input int d);
    int s;
    s = 0;
    for (int i = 0; i < NUM; i++) s += p_m[i] * v_m[i][d];
`ifdef SOFTMAX_PV_ROUND_EN
    s += (1 << (FRAC - 1));
`endif
    s = s >>> FRAC;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present P for one cycle with start high
  task automatic start_op(input bit push_exp);
    for (int i = 0; i < NUM; i++) p_in[i] = p_m[i][7:0];
    if (push_exp)
      for (int d = 0; d < DIM; d++) exp_q.push_back(8'(ref_elem(d)));
    start = 1'b1;
    p_vld = 1'b1;
    tick();
    p_vld = 1'b0;
    for (int i = 0; i < NUM; i++) p_in[i] = 8'($urandom);
  endtask

  // driver: stream n V rows; pattern 0 = always valid, 1 = every other, 2 = random
  task automatic feed_rows(input int pattern, input int n);
    int  hs;
    int  cyc;
    bit  want;
    hs = 0;
    cyc = 0;
    rdy_cnt = 0;
    while (hs < n && cyc < 400) begin
      case (pattern)
        0:       want = 1'b1;
        1:       want = cyc[0];
        default: want = 1'($urandom_range(0, 1));
      endcase
      v_vld = want;
      for (int d = 0; d < DIM; d++) v_in[d] = want ? v_m[hs][d][7:0] : 8'($urandom);
      if (v_rdy) begin
        rdy_cnt++;
        check("row_idx", 32'(row_idx), 32'(hs % NUM));
      end
      if (want && v_rdy) hs++;
      tick();
      cyc++;
    end
    v_vld = 1'b0;
    if (hs < n) check("feed_timeout", 32'(hs), 32'(n));
  endtask

  // wait for the result; called one cycle after the last handshake
  task automatic wait_result(input string tag);
    int lat;
    lat = 1;
    check("row_idx_wrap", 32'(row_idx), 32'd0);
    while (!o_vld && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    for (int d = 0; d < DIM; d++) begin
      last_row[d] = exp_q.pop_front();
      check8({tag, "_data"}, o_data[d], last_row[d]);
    end
  endtask

  task automatic fill_v(input int val);
    for (int i = 0; i < NUM; i++)
      for (int d = 0; d < DIM; d++) v_m[i][d] = val;
  endtask

  task automatic fill_p(input int val);
    for (int i = 0; i < NUM; i++) p_m[i] = val;
  endtask

  task automatic idle_gap();
    start = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    p_vld = 1'b0;
    v_vld = 1'b0;
    for (int i = 0; i < NUM; i++) p_in[i] = '0;
    for (int d = 0; d < DIM; d++) v_in[d] = '0;
    tick();
    tick();

    // reset state
    check("rst_vld", 32'(o_vld), 32'd0);
    check("rst_rdy", 32'(v_rdy), 32'd0);
    check("rst_idx", 32'(row_idx), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    for (int d = 0; d < DIM; d++) check8("rst_data", o_data[d], 8'd0);
    rst_n = 1'b1;
    tick();

    // V_VLD in IDLE is ignored
    v_vld = 1'b1;
    tick();
    check("idle_rdy", 32'(v_rdy), 32'd0);
    check("idle_idx", 32'(row_idx), 32'd0);
    v_vld = 1'b0;

    // scenario 1: P = 1/16, V = 1.0 -> 1.0
    fill_p(2);
    fill_v(32);
    start_op(1'b1);
    feed_rows(0, NUM);
    check("s1_ready_cycles", 32'(rdy_cnt), 32'd16);
    wait_result("s1");
    check8("s1_const", o_data[0], 8'd32);
    tick();
    check("s1_pulse", 32'(o_vld), 32'd0);
    idle_gap();

    // scenario 2: one-hot P[3]
    fill_p(0);
    p_m[3] = 32;
    for (int i = 0; i < NUM; i++)
      for (int d = 0; d < DIM; d++) v_m[i][d] = $urandom_range(0, 255) - 128;
    v_m[3][0] = -16; v_m[3][1] = 8; v_m[3][2] = 127; v_m[3][3] = -128;
    start_op(1'b1);
    feed_rows(0, NUM);
    wait_result("s2");
    check8("s2_const", o_data[3], 8'h80);
    idle_gap();

    // scenario 3: saturation at both rails
    fill_p(32);
    fill_v(127);
    start_op(1'b1);
    feed_rows(0, NUM);
    wait_result("s3_hi");
    check8("s3_hi_const", o_data[1], 8'd127);
    idle_gap();
    fill_v(-128);
    start_op(1'b1);
    feed_rows(2, NUM);
    wait_result("s3_lo");
    idle_gap();

    // scenario 4: valid toggles every other cycle
    fill_p(2);
    fill_v(32);
    start_op(1'b1);
    feed_rows(1, NUM);
    wait_result("s4");
    idle_gap();

    // scenario 5: abort after 5 handshakes
    start_op(1'b0);
    feed_rows(0, 5);
    check("abort_idx", 32'(row_idx), 32'd5);
    start = 1'b0;
    v_vld = 1'b1;
    tick();
    v_vld = 1'b0;
    check("abort_rdy", 32'(v_rdy), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    for (int c = 0; c < 4; c++) begin
      check("abort_no_vld", 32'(o_vld), 32'd0);
      tick();
    end
    for (int d = 0; d < DIM; d++) check8("abort_data_held", o_data[d], last_row[d]);

    // rerun scenario 1 after abort
    start_op(1'b1);
    feed_rows(0, NUM);
    wait_result("s5_rerun");
    idle_gap();

    // reset mid-ACC
    start_op(1'b0);
    feed_rows(0, 3);
    rst_n = 1'b0;
    tick();
    check("mid_rst_vld", 32'(o_vld), 32'd0);
    check("mid_rst_rdy", 32'(v_rdy), 32'd0);
    check("mid_rst_idx", 32'(row_idx), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    for (int d = 0; d < DIM; d++) check8("mid_rst_data", o_data[d], 8'd0);
    rst_n = 1'b1;
    idle_gap();

    // scenario 6: 0.5 * 1 LSB -> truncates to 0 or rounds to 1
    fill_p(0);
    p_m[0] = 16;
    fill_v(0);
    for (int d = 0; d < DIM; d++) v_m[0][d] = 1;
    start_op(1'b1);
    feed_rows(0, NUM);
    wait_result("s6");
`ifdef SOFTMAX_PV_ROUND_EN
    check8("s6_const", o_data[2], 8'd1);
`else
    check8("s6_const", o_data[2], 8'd0);
`endif
    idle_gap();

    // randomized rows with random backpressure
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NUM; i++) p_m[i] = $urandom_range(0, 8);
      for (int i = 0; i < NUM; i++)
        for (int d = 0; d < DIM; d++) v_m[i][d] = $urandom_range(0, 255) - 128;
      start_op(1'b1);
      feed_rows(2, NUM);
      wait_result("rand");
      idle_gap();
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
